mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single unified memory of the multicycle RISC-V core between two
//   requesters: the core (fetch/load/store, port C) and a program loader/DMA
//   (port L). Per-port req/gnt/rvalid handshake, round-robin fairness, bounded
//   loader burst lock. Sits between the core address mux and the memory instance.
// PARAMETERS
//   AW         32  address width, both ports and memory
//   DW         32  data width
//   MAX_BURST   8  max consecutive locked loader beats before a forced release
// PORTS
//   clk          in   1   system clock, all state updates on rising edge
//   reset        in   1   asynchronous, active-low reset (0 = reset)
//   c_req        in   1   core requests one access this cycle
//   c_we         in   1   core access is a write
//   c_addr       in   AW  core address
//   c_wdata      in   DW  core write data
//   c_gnt        out  1   core access accepted this cycle
//   c_stall      out  1   c_req & ~c_gnt; core holds PCWrite/IRWrite while high
//   c_rdata      out  DW  core read data, valid with c_rvalid
//   c_rvalid     out  1   one-cycle pulse, cycle after an accepted core read
//   l_req, l_we, l_addr, l_wdata   in  1/1/AW/DW  loader request (as core)
//   l_lock       in   1   loader requests to keep ownership for the next beat
//   l_gnt, l_rdata, l_rvalid       out 1/DW/1    loader response (as core)
//   mem_address  out  AW  to memory address
//   mem_data_in  out  DW  to memory write data
//   mem_we       out  1   to memory write enable
//   mem_data_out in   DW  memory read data, combinational from mem_address
// BEHAVIOUR
//   - Reset values: all gnt/rvalid/stall 0, rdata 0, mem_we 0, mem_address 0,
//     mem_data_in 0, state IDLE, last_owner=L (core wins first tie), burst_cnt 0.
//   - Accept: at most one gnt per cycle, combinational from req and state.
//     Granted port's addr/wdata/we drive memory the same cycle. Read data
//     captured on that edge; rvalid pulses the following cycle. Write commits at
//     the grant edge; no rvalid for writes. No grant: mem_we=0, mem_address=0.
//   - Requester holds req/addr/we/wdata stable until it sees gnt; gnt is the
//     only acceptance. Deasserting req before gnt withdraws without side effect.
//   - States: IDLE (no owner history this beat), RR (normal arbitration),
//     LOCK (loader owns). Transitions:
//       IDLE/RR: only one req -> grant it; both -> grant port != last_owner;
//         L granted with l_lock=1 -> LOCK, burst_cnt=1. No req -> IDLE.
//       LOCK: l_req -> grant L regardless of c_req, burst_cnt++;
//         l_lock=0 or l_req=0 -> RR; burst_cnt==MAX_BURST -> RR, last_owner=L,
//         and L denied next cycle if c_req=1 (forced release).
//   - last_owner updated to granted port each accepted beat.
//   - Core worst-case wait: MAX_BURST+1 cycles while core req held.
//   - rvalid of C and L never asserted together; rdata holds last value when
//     rvalid=0.
//   - Reset mid-burst or mid-read: async clear, pending rvalid dropped, state
//     IDLE; no mem_we while reset=0.
// TESTING
//   1. Reset low, reqs high -> all gnt 0, mem_we 0; release reset: c_gnt=1 first
//      (last_owner=L).
//   2. Core read 0x10, mem=0xDEADBEEF -> c_gnt cycle N, c_rvalid=1,
//      c_rdata=0xDEADBEEF cycle N+1; l_* outputs stay 0.
//   3. Both req continuously, no lock -> grants alternate C,L,C,L for 8 cycles.
//   4. Loader l_lock=1 16 beats, c_req held -> 8 L grants, then c_gnt, then
//      L resumes; c_stall high exactly 8 cycles.
//   5. Loader write 0x20=0x12345678 then core read 0x20 -> mem_we only on L
//      grant cycle, core rdata 0x12345678, no l_rvalid.
//   6. Assert reset during LOCK with pending read -> no rvalid after reset;
//      state IDLE, burst_cnt 0, next tie granted to core.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing the core's unified memory between the core (C) and a
// program loader/DMA (L): round-robin fairness with a bounded loader burst lock.
module mem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_stall,
    output logic [DW-1:0] c_rdata,
    output logic          c_rvalid,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    input  logic          l_lock,
    output logic          l_gnt,
    output logic [DW-1:0] l_rdata,
    output logic          l_rvalid,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_in,
    output logic          mem_we,
    input  logic [DW-1:0] mem_data_out
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        RR,
        LOCK
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          last_owner;
    logic          last_owner_next;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] burst_next;
    logic [CW-1:0] burst_inc;

    assign burst_inc = burst_cnt + 1'b1;

    // last_owner = 1 means the loader had the previous beat, so the core wins a tie.
    // Reaching MAX_BURST drops back to RR with last_owner=L, which hands the core
    // the next tie and bounds its wait.
    always_comb begin
        c_gnt           = 1'b0;
        l_gnt           = 1'b0;
        state_next      = state;
        last_owner_next = last_owner;
        burst_next      = burst_cnt;
        if (reset) begin
            if (state == LOCK && l_req) begin
                l_gnt = 1'b1;
            end else if (c_req && l_req) begin
                c_gnt = last_owner;
                l_gnt = ~last_owner;
            end else begin
                c_gnt = c_req;
                l_gnt = l_req;
            end

            if (c_gnt) begin
                last_owner_next = 1'b0;
                burst_next      = '0;
                state_next      = RR;
            end else if (l_gnt) begin
                last_owner_next = 1'b1;
                if (l_lock && (burst_inc < MAX_CNT)) begin
                    burst_next = burst_inc;
                    state_next = LOCK;
                end else begin
                    burst_next = '0;
                    state_next = RR;
                end
            end else begin
                burst_next = '0;
                state_next = (state == LOCK) ? RR : IDLE;
            end
        end
    end

    always_comb begin
        mem_address = '0;
        mem_data_in = '0;
        mem_we      = 1'b0;
        if (c_gnt) begin
            mem_address = c_addr;
            mem_data_in = c_wdata;
            mem_we      = c_we;
        end else if (l_gnt) begin
            mem_address = l_addr;
            mem_data_in = l_wdata;
            mem_we      = l_we;
        end
    end

    assign c_stall = reset & c_req & ~c_gnt;

    // Read data is captured on the grant edge and presented with a one-cycle
    // rvalid pulse; rdata holds its last value otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
            c_rvalid   <= 1'b0;
            l_rvalid   <= 1'b0;
            c_rdata    <= '0;
            l_rdata    <= '0;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
            burst_cnt  <= burst_next;
            c_rvalid   <= c_gnt & ~c_we;
            l_rvalid   <= l_gnt & ~l_we;
            if (c_gnt && !c_we) begin
                c_rdata <= mem_data_out;
            end
            if (l_gnt && !l_we) begin
                l_rdata <= mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two requesters following the req/gnt
// protocol, a behavioural memory, and a reference model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_req, c_we, l_req, l_we, l_lock;
    logic [AW-1:0] c_addr, l_addr;
    logic [DW-1:0] c_wdata, l_wdata;
    logic          c_gnt, c_stall, c_rvalid, l_gnt, l_rvalid, mem_we;
    logic [DW-1:0] c_rdata, l_rdata, mem_data_in, mem_data_out;
    logic [AW-1:0] mem_address;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rdata(l_rdata), .l_rvalid(l_rvalid),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_we(mem_we),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed_word(input int idx);
        return 32'h5A00_0000 ^ (32'(idx) * 32'h0001_0203);
    endfunction

    // Memory fixture seen by the DUT; unwritten words read their seed pattern.
    bit [31:0] fix_mem [256];
    bit        fix_wr  [256];
    assign mem_data_out = fix_wr[mem_address[9:2]] ? fix_mem[mem_address[9:2]]
                                                   : seed_word(int'(mem_address[9:2]));
    always @(posedge clk) begin
        if (mem_we) begin
            fix_mem[mem_address[9:2]] <= mem_data_in;
            fix_wr[mem_address[9:2]]  <= 1'b1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Reference model: memory contents, who had the last beat, and how many
    // consecutive locked loader beats have been granted so far.
    logic [31:0] ref_mem [256];
    bit          m_last_l;
    int          m_beats;
    bit          m_rv_c, m_rv_l;
    logic [31:0] m_rd_c, m_rd_l;

    // Requester state: a transaction is held until the model says it was granted.
    bit          c_pend, l_pend;
    logic        c_we_t, l_we_t, l_lock_t;
    logic [31:0] c_addr_t, l_addr_t, c_wdata_t, l_wdata_t;
    int          p_req, p_lock, p_wd, addr_max;

    task automatic applyStimulus(input bit hold_reset);
        bit          eg_c, eg_l;
        logic [31:0] e_addr, e_data;
        logic        e_we;
        int          idx;
        @(negedge clk);
        if (!c_pend && $urandom_range(0, 99) < p_req) begin
            c_pend    = 1'b1;
            c_we_t    = 1'($urandom_range(0, 1));
            c_addr_t  = 32'($urandom_range(0, addr_max)) << 2;
            c_wdata_t = $urandom;
        end else if (c_pend && $urandom_range(0, 99) < p_wd) begin
            c_pend = 1'b0;
        end
        if (!l_pend && $urandom_range(0, 99) < p_req) begin
            l_pend    = 1'b1;
            l_we_t    = 1'($urandom_range(0, 1));
            l_addr_t  = 32'($urandom_range(0, addr_max)) << 2;
            l_wdata_t = $urandom;
            l_lock_t  = ($urandom_range(0, 99) < p_lock);
        end else if (l_pend && $urandom_range(0, 99) < p_wd) begin
            l_pend = 1'b0;
        end
        reset   = ~hold_reset;
        c_req   = c_pend;
        c_we    = c_we_t;
        c_addr  = c_addr_t;
        c_wdata = c_wdata_t;
        l_req   = l_pend;
        l_we    = l_we_t;
        l_addr  = l_addr_t;
        l_wdata = l_wdata_t;
        l_lock  = l_lock_t;
        #2;

        if (hold_reset) begin
            m_last_l = 1'b1;
            m_beats  = 0;
            m_rv_c   = 1'b0;
            m_rv_l   = 1'b0;
            m_rd_c   = '0;
            m_rd_l   = '0;
        end

        eg_c = 1'b0;
        eg_l = 1'b0;
        if (!hold_reset) begin
            if (m_beats > 0 && l_req) eg_l = 1'b1;
            else if (c_req && l_req) begin
                if (m_last_l) eg_c = 1'b1;
                else          eg_l = 1'b1;
            end else begin
                eg_c = c_req;
                eg_l = l_req;
            end
        end
        e_addr = eg_c ? c_addr : (eg_l ? l_addr : 32'd0);
        e_data = eg_c ? c_wdata : (eg_l ? l_wdata : 32'd0);
        e_we   = (eg_c & c_we) | (eg_l & l_we);

        checkOutput("c_gnt", c_gnt, eg_c);
        checkOutput("l_gnt", l_gnt, eg_l);
        checkOutput("c_stall", c_stall, !hold_reset && c_req && !eg_c);
        checkOutput("mem_we", mem_we, e_we);
        checkOutput("mem_address", mem_address, e_addr);
        checkOutput("mem_data_in", mem_data_in, e_data);
        checkOutput("c_rvalid", c_rvalid, m_rv_c);
        checkOutput("l_rvalid", l_rvalid, m_rv_l);
        checkOutput("c_rdata", c_rdata, m_rd_c);
        checkOutput("l_rdata", l_rdata, m_rd_l);

        if (!hold_reset) begin
            idx    = int'(e_addr[9:2]);
            m_rv_c = eg_c && !c_we;
            m_rv_l = eg_l && !l_we;
            if (m_rv_c) m_rd_c = ref_mem[idx];
            if (m_rv_l) m_rd_l = ref_mem[idx];
            if (e_we) ref_mem[idx] = e_data;
            if (eg_c) begin
                m_last_l = 1'b0;
                m_beats  = 0;
                c_pend   = 1'b0;
            end else if (eg_l) begin
                m_last_l = 1'b1;
                l_pend   = 1'b0;
                m_beats  = l_lock ? m_beats + 1 : 0;
                if (m_beats == MAX_BURST) m_beats = 0;
            end else begin
                m_beats = 0;
            end
        end
    endtask

    int run;
    int max_run;

    initial begin
        reset  = 1'b0;
        c_req  = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        l_req  = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0; l_lock = 1'b0;
        c_pend = 1'b0; l_pend = 1'b0;
        c_we_t = 1'b0; l_we_t = 1'b0; l_lock_t = 1'b0;
        c_addr_t = '0; l_addr_t = '0; c_wdata_t = '0; l_wdata_t = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);

        // Held in reset with both ports requesting, then released.
        p_req = 100; p_lock = 0; p_wd = 0; addr_max = 63;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0);

        // Loader always locking while the core keeps requesting.
        p_lock  = 100;
        run     = 0;
        max_run = 0;
        for (int i = 0; i < 45; i++) begin
            applyStimulus(1'b0);
            run     = c_stall ? run + 1 : 0;
            max_run = (run > max_run) ? run : max_run;
        end
        checkOutput("max_core_stall", 32'(max_run), 32'(MAX_BURST));

        // Reset in the middle of a locked burst, then a tie must go to the core.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1);
        p_lock = 0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0);

        // Narrow address range so writes and reads collide often.
        p_req = 60; p_lock = 20; p_wd = 3; addr_max = 3;
        for (int i = 0; i < 200; i++) applyStimulus(1'b0);

        // Broad random traffic with occasional resets.
        p_req = 50; p_lock = 40; p_wd = 3; addr_max = 63;
        for (int i = 0; i < 1500; i++) applyStimulus($urandom_range(0, 99) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
